// File: rtl/pipe_mem_stage.sv
// rtl/pipe_mem_stage.sv - memory stage: data-memory access FSM, load/store lanes, writeback select
//
// Purpose
//   Takes the M-side bundle from the EXE/MEM register, runs loads and stores
//   over a variable-latency req/ack data-memory port, stalls the upstream
//   pipeline while an access is outstanding, and registers the final
//   register-file / HI / LO write data into the W-side bundle.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   Malu                      ALU result / effective address
//   Ma, Mb                    rs value (mthi/mtlo source), rt store data
//   Mhi..Mcounter             writeback candidates
//   Mcuttersource, Msign      access size (00/11 word, 01 half, 10 byte), sign-extend
//   Mrfsource                 rf data select (1 = load data, see rf_mux)
//   Mhisource, Mlosource      HI/LO data select
//   Mrn, Mw_rf/hi/lo/dm       destination and write enables
//   dm_*                      data-memory request port (zero unless dm_req)
//   mem_stall                 hold PC/IF/ID/EX and EXE/MEM register
//   W*                        registered writeback bundle
//
// Configuration
//   PIPE_MEM_MISALIGN_EN      flag misaligned word/half accesses instead of issuing them

module pipe_mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Malu,
   input  logic [31:0] Ma,
   input  logic [31:0] Mb,
   input  logic [31:0] Mhi,
   input  logic [31:0] Mlo,
   input  logic [31:0] Mmuler_hi,
   input  logic [31:0] Mmuler_lo,
   input  logic [31:0] Mq,
   input  logic [31:0] Mr,
   input  logic [31:0] Mpc4,
   input  logic [31:0] Mcp0,
   input  logic [31:0] Mcounter,
   input  logic [1:0]  Mcuttersource,
   input  logic        Msign,
   input  logic [2:0]  Mrfsource,
   input  logic [1:0]  Mhisource,
   input  logic [1:0]  Mlosource,
   input  logic [4:0]  Mrn,
   input  logic        Mw_rf,
   input  logic        Mw_hi,
   input  logic        Mw_lo,
   input  logic        Mw_dm,
   output logic        dm_req,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_wdata,
   input  logic [31:0] dm_rdata,
   input  logic        dm_ack,
   output logic        mem_stall,
   output logic [31:0] Wrf_data,
   output logic [31:0] Whi,
   output logic [31:0] Wlo,
   output logic [4:0]  Wrn,
   output logic        Ww_rf,
   output logic        Ww_hi,
   output logic        Ww_lo,
   output logic        Wmisalign
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

   state_t      state;
   logic [31:0] rdata_q;

   logic        access;
   logic        misalign;
   logic        start;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic [31:0] rf_mux;
   logic [31:0] hi_mux;
   logic [31:0] lo_mux;

   always_comb access = Mw_dm | ((Mrfsource == 3'd1) & Mw_rf);

`ifdef PIPE_MEM_MISALIGN_EN
   always_comb begin
      misalign = 1'b0;
      case (Mcuttersource)
         2'b01:   misalign = access & Malu[0];
         2'b10:   misalign = 1'b0;
         default: misalign = access & (Malu[1:0] != 2'b00);
      endcase
   end
`else
   always_comb misalign = 1'b0;
`endif

   // A flagged misaligned access never enters the FSM.
   always_comb start = access & ~misalign;

   // IDLE must stall in the same cycle the memory instruction arrives, so the
   // stall is decoded from the state plus the live M-side request.
   always_comb mem_stall = ~rst & (((state == S_IDLE) & start) | (state == S_REQ));

   always_comb dm_req = (state == S_REQ);

   always_comb begin
      be = 4'b1111;
      case (Mcuttersource)
         2'b01:   be = Malu[1] ? 4'b1100 : 4'b0011;
         2'b10:   be = 4'b0001 << Malu[1:0];
         default: be = 4'b1111;
      endcase
   end

   always_comb begin
      wdata = Mb;
      case (Mcuttersource)
         2'b01:   wdata = {2{Mb[15:0]}};
         2'b10:   wdata = {4{Mb[7:0]}};
         default: wdata = Mb;
      endcase
   end

   always_comb begin
      dm_we    = dm_req & Mw_dm;
      dm_addr  = dm_req ? {Malu[31:2], 2'b00} : 32'd0;
      dm_be    = dm_req ? be : 4'd0;
      dm_wdata = dm_req ? wdata : 32'd0;
   end

   // Lane extraction from the latched read word.
   always_comb begin
      byte_sel = rdata_q[7:0];
      case (Malu[1:0])
         2'd0: byte_sel = rdata_q[7:0];
         2'd1: byte_sel = rdata_q[15:8];
         2'd2: byte_sel = rdata_q[23:16];
         2'd3: byte_sel = rdata_q[31:24];
         default: byte_sel = rdata_q[7:0];
      endcase
      half_sel = Malu[1] ? rdata_q[31:16] : rdata_q[15:0];
   end

   always_comb begin
      load_data = rdata_q;
      case (Mcuttersource)
         2'b01:   load_data = {{16{Msign & half_sel[15]}}, half_sel};
         2'b10:   load_data = {{24{Msign & byte_sel[7]}}, byte_sel};
         default: load_data = rdata_q;
      endcase
   end

   always_comb begin
      rf_mux = Malu;
      case (Mrfsource)
         3'd1:    rf_mux = load_data;
         3'd2:    rf_mux = Mpc4;
         3'd3:    rf_mux = Mhi;
         3'd4:    rf_mux = Mlo;
         3'd5:    rf_mux = Mcp0;
         3'd6:    rf_mux = Mcounter;
         default: rf_mux = Malu;
      endcase
   end

   always_comb begin
      hi_mux = Ma;
      lo_mux = Ma;
      case (Mhisource)
         2'b01:   hi_mux = Mmuler_hi;
         2'b10:   hi_mux = Mr;
         2'b11:   hi_mux = Mhi;
         default: hi_mux = Ma;
      endcase
      case (Mlosource)
         2'b01:   lo_mux = Mmuler_lo;
         2'b10:   lo_mux = Mq;
         2'b11:   lo_mux = Mlo;
         default: lo_mux = Ma;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rdata_q   <= 32'd0;
         Wrf_data  <= 32'd0;
         Whi       <= 32'd0;
         Wlo       <= 32'd0;
         Wrn       <= 5'd0;
         Ww_rf     <= 1'b0;
         Ww_hi     <= 1'b0;
         Ww_lo     <= 1'b0;
         Wmisalign <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) state <= S_REQ;
            S_REQ: begin
               if (dm_ack) begin
                  rdata_q <= dm_rdata;
                  state   <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         if (mem_stall) begin
            // Bubble: kill write enables, keep data so W stays quiet.
            Ww_rf     <= 1'b0;
            Ww_hi     <= 1'b0;
            Ww_lo     <= 1'b0;
            Wmisalign <= 1'b0;
         end else begin
            Wrf_data  <= rf_mux;
            Whi       <= hi_mux;
            Wlo       <= lo_mux;
            Wrn       <= Mrn;
            Ww_rf     <= Mw_rf & ~misalign;
            Ww_hi     <= Mw_hi;
            Ww_lo     <= Mw_lo;
            Wmisalign <= misalign;
         end
      end
   end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// tb/tb_pipe_mem_stage.sv - scoreboard bench for pipe_mem_stage

module tb_pipe_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Malu, Ma, Mb, Mhi, Mlo, Mmuler_hi, Mmuler_lo, Mq, Mr, Mpc4, Mcp0, Mcounter;
   logic [1:0]  Mcuttersource, Mhisource, Mlosource;
   logic        Msign;
   logic [2:0]  Mrfsource;
   logic [4:0]  Mrn;
   logic        Mw_rf, Mw_hi, Mw_lo, Mw_dm;
   logic        dm_req, dm_we, dm_ack;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;
   logic        mem_stall;
   logic [31:0] Wrf_data, Whi, Wlo;
   logic [4:0]  Wrn;
   logic        Ww_rf, Ww_hi, Ww_lo, Wmisalign;

   pipe_mem_stage dut (
      .clk(clk), .rst(rst),
      .Malu(Malu), .Ma(Ma), .Mb(Mb), .Mhi(Mhi), .Mlo(Mlo),
      .Mmuler_hi(Mmuler_hi), .Mmuler_lo(Mmuler_lo), .Mq(Mq), .Mr(Mr),
      .Mpc4(Mpc4), .Mcp0(Mcp0), .Mcounter(Mcounter),
      .Mcuttersource(Mcuttersource), .Msign(Msign), .Mrfsource(Mrfsource),
      .Mhisource(Mhisource), .Mlosource(Mlosource), .Mrn(Mrn),
      .Mw_rf(Mw_rf), .Mw_hi(Mw_hi), .Mw_lo(Mw_lo), .Mw_dm(Mw_dm),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_stall(mem_stall),
      .Wrf_data(Wrf_data), .Whi(Whi), .Wlo(Wlo), .Wrn(Wrn),
      .Ww_rf(Ww_rf), .Ww_hi(Ww_hi), .Ww_lo(Ww_lo), .Wmisalign(Wmisalign)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] rf, hi, lo;
      logic [4:0]  rn;
      logic        w_rf, w_hi, w_lo, mis;
   } w_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } r_t;

   w_t          exp_q[$];
   r_t          req_q[$];
   r_t          cur_req;
   bit          cur_valid = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          ack_k = 0;
   logic [31:0] ack_data = 32'd0;
   int          req_cnt = 0;
   bit          tb_valid = 0;
   int          next_id = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic w_t mk_w(input logic [31:0] rf, input logic [31:0] hi, input logic [31:0] lo,
                               input logic [4:0] rn, input logic w_rf, input logic w_hi,
                               input logic w_lo, input logic mis);
      w_t w;
      w.id = 0; w.rf = rf; w.hi = hi; w.lo = lo; w.rn = rn;
      w.w_rf = w_rf; w.w_hi = w_hi; w.w_lo = w_lo; w.mis = mis;
      return w;
   endfunction

   function automatic r_t rq(input logic we, input logic [31:0] a, input logic [3:0] be,
                             input logic [31:0] wd);
      r_t r;
      r.we = we; r.addr = a; r.be = be; r.wdata = wd;
      return r;
   endfunction

   task automatic clear_m();
      Malu = 0; Ma = 0; Mb = 0; Mhi = 0; Mlo = 0; Mmuler_hi = 0; Mmuler_lo = 0;
      Mq = 0; Mr = 0; Mpc4 = 0; Mcp0 = 0; Mcounter = 0;
      Mcuttersource = 0; Msign = 0; Mrfsource = 0; Mhisource = 0; Mlosource = 0;
      Mrn = 0; Mw_rf = 0; Mw_hi = 0; Mw_lo = 0; Mw_dm = 0;
   endtask

   // Called at a falling edge with M inputs already set; returns at the falling
   // edge after the instruction has left M.
   task automatic issue(input w_t e_in, input bit has_req, input r_t r, input int k,
                        input logic [31:0] rd, input int exp_cycles, input string name);
      w_t e;
      int cycles;
      bit stalled;
      e = e_in;
      e.id = next_id;
      next_id++;
      if (has_req) req_q.push_back(r);
      exp_q.push_back(e);
      ack_k = k;
      ack_data = rd;
      tb_valid = 1;
      cycles = 0;
      do begin
         #1 stalled = mem_stall;
         @(posedge clk);
         cycles++;
         @(negedge clk);
      end while (stalled && cycles < 50);
      chk({name, "_cycles"}, cycles, exp_cycles);
      tb_valid = 0;
      clear_m();
   endtask

   // Memory responder and request checker.
   always @(negedge clk) begin
      if (dm_req) begin
         req_cnt++;
         if (req_cnt == 1) begin
            if (req_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_req: got request at addr %h, expected none", dm_addr);
               cur_valid = 0;
            end else begin
               cur_req = req_q.pop_front();
               cur_valid = 1;
            end
         end
         if (cur_valid) begin
            chk("req_we", dm_we, cur_req.we);
            chk("req_addr", dm_addr, cur_req.addr);
            chk("req_be", dm_be, cur_req.be);
            chk("req_wdata", dm_wdata, cur_req.wdata);
         end
         dm_ack = (req_cnt == ack_k);
         dm_rdata = dm_ack ? ack_data : 32'd0;
      end else begin
         req_cnt = 0;
         cur_valid = 0;
         dm_ack = 0;
         dm_rdata = 32'd0;
      end
   end

   // Writeback monitor: pops on every capture edge of an issued instruction,
   // and on every stall edge requires the bubble.
   always @(posedge clk) begin : mon
      bit cap;
      bit stl;
      w_t e;
      cap = tb_valid && !mem_stall && !rst;
      stl = mem_stall && !rst;
      #1;
      if (cap) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_w: got capture with Wrf_data %h, expected none", Wrf_data);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("W_rf_data#%0d", e.id), Wrf_data, e.rf);
            chk($sformatf("W_hi#%0d", e.id), Whi, e.hi);
            chk($sformatf("W_lo#%0d", e.id), Wlo, e.lo);
            chk($sformatf("W_rn#%0d", e.id), Wrn, e.rn);
            chk($sformatf("W_flags#%0d", e.id), {Ww_rf, Ww_hi, Ww_lo, Wmisalign},
                {e.w_rf, e.w_hi, e.w_lo, e.mis});
         end
      end
      if (stl) chk("stall_bubble", {Ww_rf, Ww_hi, Ww_lo, Wmisalign}, 4'b0000);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rtab [5];
      int cnt;
      r_t no_req;
      no_req = rq(0, 0, 0, 0);
      rtab[0] = 32'h33; rtab[1] = 32'h44; rtab[2] = 32'h55; rtab[3] = 32'h66; rtab[4] = 32'h77;

      rst = 1;
      clear_m();
      dm_ack = 0;
      dm_rdata = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_dm", {dm_req, dm_we, dm_be, mem_stall}, 7'd0);
      chk("rst_dm_addr", dm_addr, 0);
      chk("rst_dm_wdata", dm_wdata, 0);
      chk("rst_wrf", Wrf_data, 0);
      chk("rst_whilo", Whi | Wlo, 0);
      chk("rst_wctl", {Wrn, Ww_rf, Ww_hi, Ww_lo, Wmisalign}, 9'd0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);

      // ALU op
      Malu = 32'h12345678; Mrfsource = 0; Mw_rf = 1; Mrn = 3;
      issue(mk_w(32'h12345678, 0, 0, 3, 1, 0, 0, 0), 0, no_req, 1, 0, 1, "alu");

      // signed / unsigned byte load at 0x103
      Malu = 32'h103; Mcuttersource = 2'b10; Msign = 1; Mrfsource = 1; Mw_rf = 1; Mrn = 5;
      issue(mk_w(32'hFFFFFF80, 0, 0, 5, 1, 0, 0, 0), 1, rq(0, 32'h100, 4'b1000, 0),
            2, 32'h80FF_0000, 4, "lb_signed");
      Malu = 32'h103; Mcuttersource = 2'b10; Msign = 0; Mrfsource = 1; Mw_rf = 1; Mrn = 5;
      issue(mk_w(32'h00000080, 0, 0, 5, 1, 0, 0, 0), 1, rq(0, 32'h100, 4'b1000, 0),
            2, 32'h80FF_0000, 4, "lb_unsigned");

      // half store at 0x202
      Malu = 32'h202; Mb = 32'hAAAA_BEEF; Mcuttersource = 2'b01; Mw_dm = 1; Mrn = 7;
      issue(mk_w(32'h202, 0, 0, 7, 0, 0, 0, 0), 1, rq(1, 32'h200, 4'b1100, 32'hBEEF_BEEF),
            1, 0, 3, "sh");

      // mult writeback
      Mhisource = 2'b01; Mlosource = 2'b01; Mw_hi = 1; Mw_lo = 1;
      Mmuler_hi = 32'h1; Mmuler_lo = 32'h2;
      issue(mk_w(0, 32'h1, 32'h2, 0, 0, 1, 1, 0), 0, no_req, 1, 0, 1, "mult");

      // word load with concurrent HI/LO write from div results
      Malu = 32'h300; Mrfsource = 1; Mw_rf = 1; Mrn = 9;
      Mhisource = 2'b10; Mlosource = 2'b10; Mr = 32'h11; Mq = 32'h22; Mw_hi = 1; Mw_lo = 1;
      issue(mk_w(32'hCAFE_F00D, 32'h11, 32'h22, 9, 1, 1, 1, 0), 1, rq(0, 32'h300, 4'hF, 0),
            3, 32'hCAFE_F00D, 5, "lw_div");

      // misaligned word load at 0x101
      Malu = 32'h101; Mcuttersource = 2'b00; Mrfsource = 1; Mw_rf = 1; Mrn = 4;
`ifdef PIPE_MEM_MISALIGN_EN
      issue(mk_w(32'hCAFE_F00D, 0, 0, 4, 0, 0, 0, 1), 0, no_req, 1, 32'h1122_3344, 1, "lw_mis");
`else
      issue(mk_w(32'h1122_3344, 0, 0, 4, 1, 0, 0, 0), 1, rq(0, 32'h100, 4'hF, 0),
            1, 32'h1122_3344, 3, "lw_mis");
`endif

      // signed half loads, upper and lower lane
      Malu = 32'h402; Mcuttersource = 2'b01; Msign = 1; Mrfsource = 1; Mw_rf = 1; Mrn = 10;
      issue(mk_w(32'hFFFF_8001, 0, 0, 10, 1, 0, 0, 0), 1, rq(0, 32'h400, 4'b1100, 0),
            1, 32'h8001_7FFF, 3, "lh_hi");
      Malu = 32'h400; Mcuttersource = 2'b01; Msign = 1; Mrfsource = 1; Mw_rf = 1; Mrn = 11;
      issue(mk_w(32'hFFFF_F00F, 0, 0, 11, 1, 0, 0, 0), 1, rq(0, 32'h400, 4'b0011, 0),
            2, 32'h8001_F00F, 4, "lh_lo");

      // byte store and word store
      Malu = 32'h501; Mb = 32'h1234_56A5; Mcuttersource = 2'b10; Mw_dm = 1;
      issue(mk_w(32'h501, 0, 0, 0, 0, 0, 0, 0), 1, rq(1, 32'h500, 4'b0010, 32'hA5A5_A5A5),
            2, 0, 4, "sb");
      Malu = 32'h600; Mb = 32'hDEAD_BEEF; Mcuttersource = 2'b11; Mw_dm = 1;
      issue(mk_w(32'h600, 0, 0, 0, 0, 0, 0, 0), 1, rq(1, 32'h600, 4'hF, 32'hDEAD_BEEF),
            1, 0, 3, "sw");

      // mthi / HI-LO forward, jal-style pc4 writeback
      Ma = 32'h55; Mlo = 32'h66; Mhisource = 2'b00; Mlosource = 2'b11; Mw_hi = 1; Mw_lo = 1;
      Mpc4 = 32'h1004; Mrfsource = 2; Mw_rf = 1; Mrn = 31;
      issue(mk_w(32'h1004, 32'h55, 32'h66, 31, 1, 1, 1, 0), 0, no_req, 1, 0, 1, "pc4_mthi");

      // remaining rf sources 3..7
      for (int i = 0; i < 5; i++) begin
         Mhi = 32'h33; Mlo = 32'h44; Mcp0 = 32'h55; Mcounter = 32'h66; Malu = 32'h77;
         Mhisource = 2'b11; Mlosource = 2'b11;
         Mrfsource = 3'(i + 3); Mw_rf = 1; Mrn = 5'(i + 3);
         issue(mk_w(rtab[i], 32'h33, 32'h44, 5'(i + 3), 1, 0, 0, 0), 0, no_req, 1, 0, 1, "rfsrc");
      end

      // reset in the second REQ cycle of a k=5 load
      Malu = 32'h700; Mrfsource = 1; Mw_rf = 1; Mrn = 6; Mw_hi = 1;
      req_q.push_back(rq(0, 32'h700, 4'hF, 0));
      ack_k = 5;
      ack_data = 32'h5555_AAAA;
      tb_valid = 1;
      cnt = 0;
      while (!dm_req && cnt < 20) begin
         @(negedge clk);
         #1;
         cnt++;
      end
      chk("rst_req_seen", dm_req, 1);
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      chk("rst_mid_dm", {dm_req, dm_we, dm_be, mem_stall}, 7'd0);
      chk("rst_mid_addr", dm_addr, 0);
      chk("rst_mid_w", {Wrf_data | Whi | Wlo}, 0);
      chk("rst_mid_wctl", {Wrn, Ww_rf, Ww_hi, Ww_lo, Wmisalign}, 9'd0);
      @(negedge clk);
      rst = 0;
      tb_valid = 0;
      clear_m();
      @(negedge clk);
      #1;
      chk("post_rst_idle", {dm_req, mem_stall, Ww_rf, Ww_hi}, 4'd0);

      repeat (2) @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 0);
      chk("req_q_drained", req_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
